// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the multiplexed 7-segment scan driver.
//   NUM_POS     - number of display positions scanned
//   BCD_DIGITS  - number of BCD digits carried by one captured word
//   SEG_*       - active-low cathode patterns {dp,g,f,e,d,c,b,a}; dp always off
package seg_pkg;

    localparam int NUM_POS    = 8;
    localparam int BCD_DIGITS = 6;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/seg_scan_driver_if.sv
// seg_scan_driver_if: BCD input strobe and display outputs of the scan driver.
//   bcd_i       - six BCD digits, [3:0] = position 0 ... [23:20] = position 5
//   bcd_valid_i - one-cycle strobe marking bcd_i as a finished conversion
//   anode       - active-low position select, bit k = position k
//   cathode     - active-low segments {dp,g,f,e,d,c,b,a}
//   frame_o     - one-cycle pulse when the scan wraps from position 7 to 0
//   pending_o   - a captured word is waiting for the next frame boundary
// master: producer/observer side; slave: the scan driver.
interface seg_scan_driver_if;
    import seg_pkg::*;

    logic [4*BCD_DIGITS-1:0] bcd_i;
    logic                    bcd_valid_i;
    logic [NUM_POS-1:0]      anode;
    logic [7:0]              cathode;
    logic                    frame_o;
    logic                    pending_o;

    modport master (
        output bcd_i, bcd_valid_i,
        input  anode, cathode, frame_o, pending_o
    );

    modport slave (
        input  bcd_i, bcd_valid_i,
        output anode, cathode, frame_o, pending_o
    );

endinterface

// File: rtl/seg_bcd_decode.sv
// seg_bcd_decode: combinational BCD nibble to active-low cathode pattern.
//   i_nib   - BCD nibble; values above 9 show a dash
//   i_blank - force all segments off
//   o_seg   - active-low cathode pattern {dp,g,f,e,d,c,b,a}
module seg_bcd_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_nib,
    input  logic       i_blank,
    output logic [7:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        if (i_blank) begin
            o_seg = SEG_BLANK;
        end else begin
            case (i_nib)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 8-position multiplexed 7-segment display driver.
// Captures finished 6-digit BCD words into a shadow register and commits
// them to the displayed (active) word only at the frame wrap, so a frame
// never mixes digits of two words. One position is shown per scan tick.
//   clk      - display/refresh clock
//   rst_n    - asynchronous active-low reset
//   bus      - seg_scan_driver_if.slave (bcd_i, bcd_valid_i, anode,
//              cathode, frame_o, pending_o)
// Parameter SCAN_DIV (>=1): clock cycles per scan tick.
// Optional macro SEG_LZB_EN: blank leading zeros on positions 1..5.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    seg_scan_driver_if.slave   bus
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0]           r_presc;
    logic [2:0]              r_idx;
    logic [4*BCD_DIGITS-1:0] r_shadow;
    logic [4*BCD_DIGITS-1:0] r_active;
    logic                    r_pending;
    logic                    r_frame;
    logic [NUM_POS-1:0]      r_anode;
    logic [7:0]              r_cathode;

    logic                    w_tick;
    logic                    w_wrap;
    logic [3:0]              w_cur_nib;
    logic                    w_cur_blank;
    logic [7:0]              w_seg;

    assign w_tick = (r_presc == PW'(SCAN_DIV - 1));
    assign w_wrap = w_tick && (r_idx == 3'd7);

    // Prescaler and scan position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
            r_idx   <= r_idx + 3'd1;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // Capture and frame-boundary commit. A strobe in the wrap cycle lands in
    // the shadow after the old shadow has moved to active, so pending stays set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow  <= '0;
            r_active  <= '0;
            r_pending <= 1'b0;
            r_frame   <= 1'b0;
        end else begin
            r_frame <= w_wrap;
            if (w_wrap && r_pending) begin
                r_active  <= r_shadow;
                r_pending <= 1'b0;
            end
            if (bus.bcd_valid_i) begin
                r_shadow  <= bus.bcd_i;
                r_pending <= 1'b1;
            end
        end
    end

`ifdef SEG_LZB_EN
    // w_lz[k]: nibble k and every higher nibble up to position 5 are zero
    logic [BCD_DIGITS:0] w_lz;
    always_comb begin
        w_lz[BCD_DIGITS] = 1'b1;
        for (int k = BCD_DIGITS - 1; k >= 0; k--) begin
            w_lz[k] = (r_active[4*k +: 4] == 4'd0) && w_lz[k+1];
        end
    end
`endif

    // Digit and blank selection for the current position; 6 and 7 are unused
    always_comb begin
        w_cur_nib   = 4'd0;
        w_cur_blank = 1'b1;
        case (r_idx)
            3'd0: begin w_cur_nib = r_active[3:0];   w_cur_blank = 1'b0; end
`ifdef SEG_LZB_EN
            3'd1: begin w_cur_nib = r_active[7:4];   w_cur_blank = w_lz[1]; end
            3'd2: begin w_cur_nib = r_active[11:8];  w_cur_blank = w_lz[2]; end
            3'd3: begin w_cur_nib = r_active[15:12]; w_cur_blank = w_lz[3]; end
            3'd4: begin w_cur_nib = r_active[19:16]; w_cur_blank = w_lz[4]; end
            3'd5: begin w_cur_nib = r_active[23:20]; w_cur_blank = w_lz[5]; end
`else
            3'd1: begin w_cur_nib = r_active[7:4];   w_cur_blank = 1'b0; end
            3'd2: begin w_cur_nib = r_active[11:8];  w_cur_blank = 1'b0; end
            3'd3: begin w_cur_nib = r_active[15:12]; w_cur_blank = 1'b0; end
            3'd4: begin w_cur_nib = r_active[19:16]; w_cur_blank = 1'b0; end
            3'd5: begin w_cur_nib = r_active[23:20]; w_cur_blank = 1'b0; end
`endif
            default: begin w_cur_nib = 4'd0; w_cur_blank = 1'b1; end
        endcase
    end

    seg_bcd_decode u_dec (
        .i_nib   (w_cur_nib),
        .i_blank (w_cur_blank),
        .o_seg   (w_seg)
    );

    // Output registers: one cycle behind r_idx
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_anode   <= '1;
            r_cathode <= SEG_BLANK;
        end else begin
            r_anode   <= ~(NUM_POS'(1) << r_idx);
            r_cathode <= w_seg;
        end
    end

    assign bus.anode     = r_anode;
    assign bus.cathode   = r_cathode;
    assign bus.frame_o   = r_frame;
    assign bus.pending_o = r_pending;

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

    localparam int SCAN_DIV = 4;

`ifdef SEG_LZB_EN
    localparam logic [7:0] LZ = 8'hFF;
`else
    localparam logic [7:0] LZ = 8'hC0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    seg_scan_driver_if bus ();

    seg_scan_driver #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic strobe(input logic [23:0] v);
        bus.bcd_i       = v;
        bus.bcd_valid_i = 1'b1;
        @(negedge clk);
        bus.bcd_valid_i = 1'b0;
    endtask

    // Advance to the negedge where frame_o is high (bounded)
    task automatic wait_frame(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.frame_o !== 1'b1 && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_frame_seen"}, {7'b0, bus.frame_o}, 8'h01);
    endtask

    // Walk positions 0..7 of the frame starting now; e[8p+7:8p] = position p
    task automatic scan_frame(input logic [63:0] e, input string tag);
        for (int p = 0; p < 8; p++) begin
            logic [7:0] tgt;
            int         n;
            tgt = ~(8'(1) << p);
            n   = 0;
            while (bus.anode !== tgt && n < 4 * SCAN_DIV) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("%s_anode%0d", tag, p), bus.anode, tgt);
            chk($sformatf("%s_pos%0d", tag, p), bus.cathode, e[p*8 +: 8]);
        end
    endtask

    initial begin
        int n;
        checks          = 0;
        errors          = 0;
        rst_n           = 1'b1;
        bus.bcd_i       = '0;
        bus.bcd_valid_i = 1'b0;

        // Reset held for 5 cycles
        #1 rst_n = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_anode",   bus.anode,   8'hFF);
        chk("rst_cathode", bus.cathode, 8'hFF);
        chk("rst_frame",   {7'b0, bus.frame_o},   8'h00);
        chk("rst_pending", {7'b0, bus.pending_o}, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_anode",   bus.anode,   8'hFE);
        chk("rel_cathode", bus.cathode, 8'hC0);
        repeat (4) @(negedge clk);
        chk("pos1_anode",   bus.anode,   8'hFD);
        chk("pos1_cathode", bus.cathode, LZ);

        // Frame period: 8 positions x SCAN_DIV cycles, pulse one cycle wide
        wait_frame("period");
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) chk("frame_width", {7'b0, bus.frame_o}, 8'h00);
        end while (bus.frame_o !== 1'b1 && n < 80);
        chk("frame_period", 8'(n), 8'd32);

        // Capture and commit of 123456
        repeat (8) @(negedge clk);
        strobe(24'h123456);
        chk("cap_pending", {7'b0, bus.pending_o}, 8'h01);
        wait_frame("cap");
        chk("cap_committed", {7'b0, bus.pending_o}, 8'h00);
        scan_frame({8'hFF, 8'hFF, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82}, "cap");

        // Last word wins
        wait_frame("lww_sync");
        repeat (3) @(negedge clk);
        strobe(24'h000111);
        repeat (2) @(negedge clk);
        strobe(24'h000222);
        chk("lww_pending", {7'b0, bus.pending_o}, 8'h01);
        wait_frame("lww");
        scan_frame({8'hFF, 8'hFF, LZ, LZ, LZ, 8'hA4, 8'hA4, 8'hA4}, "lww");

        // Strobe in the wrap-tick cycle while 5 is pending
        wait_frame("wrap_sync");
        repeat (5) @(negedge clk);
        strobe(24'h000005);
        chk("wrap_pend5", {7'b0, bus.pending_o}, 8'h01);
        repeat (25) @(negedge clk);
        bus.bcd_i       = 24'h000009;
        bus.bcd_valid_i = 1'b1;
        @(negedge clk);
        bus.bcd_valid_i = 1'b0;
        chk("wrap_frame",   {7'b0, bus.frame_o},   8'h01);
        chk("wrap_pending", {7'b0, bus.pending_o}, 8'h01);
        scan_frame({8'hFF, 8'hFF, LZ, LZ, LZ, LZ, LZ, 8'h92}, "wrap5");
        wait_frame("wrap9");
        chk("wrap9_pending", {7'b0, bus.pending_o}, 8'h00);
        scan_frame({8'hFF, 8'hFF, LZ, LZ, LZ, LZ, LZ, 8'h90}, "wrap9");

        // Invalid nibble and leading zeros
        wait_frame("inv_sync");
        repeat (3) @(negedge clk);
        strobe(24'h00A007);
        wait_frame("inv");
        scan_frame({8'hFF, 8'hFF, LZ, LZ, 8'hBF, 8'hC0, 8'hC0, 8'hF8}, "inv");

        wait_frame("zero_sync");
        repeat (3) @(negedge clk);
        strobe(24'h000000);
        wait_frame("zero");
        scan_frame({8'hFF, 8'hFF, LZ, LZ, LZ, LZ, LZ, 8'hC0}, "zero");

        // Async reset mid-frame with a word pending
        strobe(24'h000042);
        wait_frame("ar_sync");
        strobe(24'h000077);
        n = 0;
        while (bus.anode !== 8'hF7 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("ar_at_pos3",  bus.anode, 8'hF7);
        chk("ar_pend_pre", {7'b0, bus.pending_o}, 8'h01);
        rst_n = 1'b0;
        #1;
        chk("ar_anode",   bus.anode,   8'hFF);
        chk("ar_cathode", bus.cathode, 8'hFF);
        chk("ar_pending", {7'b0, bus.pending_o}, 8'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar_rel_anode",   bus.anode,   8'hFE);
        chk("ar_rel_cathode", bus.cathode, 8'hC0);
        chk("ar_rel_pending", {7'b0, bus.pending_o}, 8'h00);
        wait_frame("ar");
        chk("ar_no_commit", {7'b0, bus.pending_o}, 8'h00);
        scan_frame({8'hFF, 8'hFF, LZ, LZ, LZ, LZ, LZ, 8'hC0}, "ar");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
